// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and a helper that sizes the BCD digit count.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest digit count d with 10^d >= 2^bin_w, i.e. exact for every operand.
  function automatic int min_digits(input int bin_w);
    longint lim;
    longint p;
    int     d;
    lim = longint'(1) << bin_w;
    p   = 1;
    d   = 0;
    for (int i = 0; i < 20; i++) begin
      if (p < lim) begin
        p = p * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on the operand and result sides.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_sr_reg, bin_sr_next;
  logic [BCD_W-1:0]   bcd_sr_reg, bcd_sr_next;
  logic               ovf_sr_reg, ovf_sr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic               ovf_reg, ovf_next;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic               carry_out;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .d (bcd_sr_reg[4*gi +: 4]),
        .q (bcd_adj[4*gi +: 4])
      );
    end
  endgenerate

  // A 1 leaving the top digit means the value no longer fits; truncation
  // of that carry leaves the result modulo 10^DIGITS.
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_sr_reg[BIN_W-1]};
  assign carry_out   = bcd_adj[BCD_W-1];

  always_comb begin
    state_next  = state_reg;
    bin_sr_next = bin_sr_reg;
    bcd_sr_next = bcd_sr_reg;
    ovf_sr_next = ovf_sr_reg;
    cnt_next    = cnt_reg;
    bcd_next    = bcd_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          bin_sr_next = in_data;
          bcd_sr_next = '0;
          ovf_sr_next = 1'b0;
          cnt_next    = CNT_W'(BIN_W);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        bin_sr_next = {bin_sr_reg[BIN_W-2:0], 1'b0};
        bcd_sr_next = bcd_shifted;
        ovf_sr_next = ovf_sr_reg | carry_out;
        cnt_next    = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          bcd_next   = bcd_shifted;
          ovf_next   = ovf_sr_reg | carry_out;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      bin_sr_reg <= '0;
      bcd_sr_reg <= '0;
      ovf_sr_reg <= 1'b0;
      cnt_reg    <= '0;
      bcd_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bin_sr_reg <= bin_sr_next;
      bcd_sr_reg <= bcd_sr_next;
      ovf_sr_reg <= ovf_sr_next;
      cnt_reg    <= cnt_next;
      bcd_reg    <= bcd_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign bcd       = bcd_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: four parameterisations driven from one directed
// sequence, results compared with a decimal reference computed by div/mod.
module tb_bin_bcd_seq;
  import bin_bcd_pkg::*;

  localparam int DG8  = min_digits(8);
  localparam int DG4  = min_digits(4);
  localparam int DG12 = min_digits(12);

  logic clk;
  logic rst_n;

  logic        in_valid0, in_valid1, in_valid2, in_valid3;
  logic        out_ready0, out_ready1, out_ready2, out_ready3;
  logic [7:0]  in_data0;
  logic [3:0]  in_data1;
  logic [7:0]  in_data2;
  logic [11:0] in_data3;

  logic        in_ready0, in_ready1, in_ready2, in_ready3;
  logic        out_valid0, out_valid1, out_valid2, out_valid3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic [4*DG8-1:0]  bcd0;
  logic [4*DG4-1:0]  bcd1;
  logic [7:0]        bcd2;
  logic [4*DG12-1:0] bcd3;

  int          sel;
  logic        in_ready_m, out_valid_m, ovf_m;
  logic [15:0] bcd_m;

  int n_pass;
  int n_total;

  bin_bcd_seq #(.BIN_W(8), .DIGITS(DG8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .bcd(bcd0), .ovf(ovf0));

  bin_bcd_seq #(.BIN_W(4), .DIGITS(DG4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .bcd(bcd1), .ovf(ovf1));

  bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bcd(bcd2), .ovf(ovf2));

  bin_bcd_seq #(.BIN_W(12), .DIGITS(DG12)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .bcd(bcd3), .ovf(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_ready_m  = 1'b0;
    out_valid_m = 1'b0;
    ovf_m       = 1'b0;
    bcd_m       = '0;
    case (sel)
      0: begin in_ready_m = in_ready0; out_valid_m = out_valid0; ovf_m = ovf0; bcd_m = 16'(bcd0); end
      1: begin in_ready_m = in_ready1; out_valid_m = out_valid1; ovf_m = ovf1; bcd_m = 16'(bcd1); end
      2: begin in_ready_m = in_ready2; out_valid_m = out_valid2; ovf_m = ovf2; bcd_m = 16'(bcd2); end
      3: begin in_ready_m = in_ready3; out_valid_m = out_valid3; ovf_m = ovf3; bcd_m = 16'(bcd3); end
      default: ;
    endcase
  end

  // Reference: plain decimal digits of v, truncated to dg digits.
  function automatic logic [15:0] ref_bcd(input int v, input int dg);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < dg; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int dg);
    int p;
    p = 1;
    for (int i = 0; i < dg; i++) p = p * 10;
    return (v >= p);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic r);
    case (sel)
      0: begin in_valid0 = v; in_data0 = d[7:0];  out_ready0 = r; end
      1: begin in_valid1 = v; in_data1 = d[3:0];  out_ready1 = r; end
      2: begin in_valid2 = v; in_data2 = d[7:0];  out_ready2 = r; end
      3: begin in_valid3 = v; in_data3 = d[11:0]; out_ready3 = r; end
      default: ;
    endcase
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready_m && n < 50) begin
      step();
      n++;
    end
    chk("wait_in_ready", in_ready_m, 1);
  endtask

  // One full conversion with out_ready held high; checks latency,
  // in_ready low time, result and the return to IDLE.
  task automatic do_conv(input int val, input int bw, input int dg);
    int n;
    int low;
    wait_ready();
    drive(1'b1, val, 1'b1);
    step();
    drive(1'b0, 0, 1'b1);
    n   = 0;
    low = 0;
    while (!out_valid_m && n < 100) begin
      if (!in_ready_m) low++;
      step();
      n++;
    end
    if (!in_ready_m) low++;
    chk("latency", n, bw);
    chk("result_bcd", bcd_m, ref_bcd(val, dg));
    chk("result_ovf", ovf_m, ref_ovf(val, dg));
    $display("conv dut%0d in=%0d bcd=%h ovf=%0b lat=%0d", sel, val, bcd_m, ovf_m, n);
    step();
    chk("in_ready_low_cycles", low, bw + 1);
    chk("out_valid_cleared", out_valid_m, 0);
    chk("in_ready_back", in_ready_m, 1);
  endtask

  initial begin
    int n;
    int q[$];
    int got;
    int cyc;
    int exp_v;
    logic cur_valid;
    int cur_data;
    logic out_r;
    logic fire_in;
    logic fire_out;

    n_pass  = 0;
    n_total = 0;
    sel     = 0;
    rst_n   = 1'b0;
    in_valid0 = 0; in_valid1 = 0; in_valid2 = 0; in_valid3 = 0;
    out_ready0 = 1; out_ready1 = 1; out_ready2 = 1; out_ready3 = 1;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;

    #12;
    chk("reset_in_ready", in_ready_m, 1);
    chk("reset_out_valid", out_valid_m, 0);
    chk("reset_bcd", bcd_m, 0);
    chk("reset_ovf", ovf_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // BIN_W=8, DIGITS=3: full range, latency and in_ready timing
    sel = 0;
    do_conv(255, 8, DG8);
    do_conv(0, 8, DG8);
    do_conv(99, 8, DG8);

    // BIN_W=4, DIGITS=2: exhaustive sweep
    sel = 1;
    for (int v = 0; v < 16; v++) do_conv(v, 4, DG4);

    // BIN_W=8, DIGITS=2: overflow sets, then clears on the next conversion
    sel = 2;
    do_conv(255, 8, 2);
    do_conv(99, 8, 2);

    // Backpressure on the result side
    sel = 0;
    wait_ready();
    drive(1'b1, 137, 1'b0);
    step();
    drive(1'b0, 0, 1'b0);
    n = 0;
    while (!out_valid_m && n < 100) begin
      step();
      n++;
    end
    chk("bp_latency", n, 8);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 55, 1'b0);
      chk("bp_out_valid", out_valid_m, 1);
      chk("bp_bcd", bcd_m, 16'h0137);
      chk("bp_in_ready", in_ready_m, 0);
      step();
    end
    drive(1'b0, 0, 1'b0);
    chk("bp_bcd_final", bcd_m, 16'h0137);
    $display("backpressure dut0 in=137 bcd=%h held 6 cycles", bcd_m);
    drive(1'b0, 0, 1'b1);
    step();
    chk("bp_release_out_valid", out_valid_m, 0);
    chk("bp_release_in_ready", in_ready_m, 1);
    chk("bp_release_bcd_kept", bcd_m, 16'h0137);
    step();
    chk("bp_no_ghost_accept", in_ready_m, 1);

    // Asynchronous reset in the middle of a conversion
    wait_ready();
    drive(1'b1, 200, 1'b1);
    step();
    drive(1'b0, 0, 1'b1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready_m, 1);
    chk("arst_out_valid", out_valid_m, 0);
    chk("arst_bcd", bcd_m, 0);
    chk("arst_ovf", ovf_m, 0);
    $display("async reset dut0 during conversion of 200");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_no_stale", out_valid_m, 0);
    do_conv(42, 8, DG8);

    // Random operands with random gaps on both handshakes
    sel       = 3;
    got       = 0;
    cyc       = 0;
    cur_valid = 1'b0;
    cur_data  = 0;
    while (got < 1000 && cyc < 60000) begin
      if (!cur_valid && (got + q.size()) < 1000 && $urandom_range(0, 3) != 0) begin
        cur_valid = 1'b1;
        cur_data  = int'($urandom_range(0, 4095));
      end
      out_r = ($urandom_range(0, 3) != 0);
      drive(cur_valid, cur_valid ? cur_data : int'($urandom), out_r);
      fire_in  = cur_valid && in_ready_m;
      fire_out = out_valid_m && out_r;
      if (fire_out) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 1, 0);
        end else begin
          exp_v = q.pop_front();
          chk("rand_bcd", bcd_m, ref_bcd(exp_v, DG12));
          chk("rand_ovf", ovf_m, ref_ovf(exp_v, DG12));
          $display("rand %0d in=%0d bcd=%h ovf=%0b", got, exp_v, bcd_m, ovf_m);
        end
        got++;
      end
      if (fire_in) begin
        q.push_back(cur_data);
        cur_valid = 1'b0;
      end
      step();
      cyc++;
    end
    chk("rand_result_count", got, 1000);
    chk("rand_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
